// File: rtl/jtcop_mcu_mailbox.sv
// Main-CPU side of the i8751 mailbox: latches a 16-bit command for the MCU,
// serves it over P0 on P2 strobes and collects the 16-bit reply.
module jtcop_mcu_mailbox #(
   parameter int TOUT_W = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cs,
   input  logic        addr,
   input  logic        rnw,
   input  logic [1:0]  dsn,
   input  logic [15:0] cpu_dout,
   output logic [15:0] dout,
   input  logic [7:0]  p2o,
   input  logic [7:0]  p0o,
   output logic [7:0]  p0i,
   output logic        intn,
   output logic        rply_irqn
);

   localparam logic [TOUT_W-1:0] TOUT_MAX = '1;

   logic [15:0]       cmd;
   logic [15:0]       reply;
   logic [7:0]        p2l;
   logic [7:0]        rise;
   logic              csl;
   logic              pend;
   logic              rv;
   logic              ovr;
   logic              tout;
   logic [TOUT_W-1:0] cnt;

   logic              csr;
   logic              wr_cmd;
   logic              rd_data;
   logic              rd_stat;
   logic              tout_hit;
   logic [15:0]       status;
   logic              unused_rise;

   assign rise     = p2o & ~p2l;
   assign csr      = cs & ~csl;
   // A write with both strobes inactive touches nothing, not even the flags
   assign wr_cmd   = csr & ~rnw & ~addr & ~(&dsn);
   assign rd_data  = csr & rnw & ~addr;
   assign rd_stat  = csr & rnw & addr;
   assign tout_hit = pend & (cnt == TOUT_MAX);
   assign status   = {12'd0, tout, ovr, rv, pend};

   // P2.0-P2.2 carry no strobe and P2.3 is used as a level, not an edge
   assign unused_rise = ^rise[3:0];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cmd       <= '0;
         reply     <= '0;
         p0i       <= '0;
         dout      <= '0;
         cnt       <= '0;
         pend      <= 1'b0;
         rv        <= 1'b0;
         ovr       <= 1'b0;
         tout      <= 1'b0;
         intn      <= 1'b1;
         rply_irqn <= 1'b1;
         p2l       <= 8'hFF;
         csl       <= 1'b0;
      end else begin
         csl <= cs;
         p2l <= p2o;

         if (cs)
            dout <= addr ? status : reply;

         if (wr_cmd) begin
            if (!dsn[1]) cmd[15:8] <= cpu_dout[15:8];
            if (!dsn[0]) cmd[7:0]  <= cpu_dout[7:0];
         end

         // Low-byte strobe wins, and it sees the command before any same-cycle write
         if (rise[5])
            p0i <= cmd[7:0];
         else if (rise[4])
            p0i <= cmd[15:8];

         if (wr_cmd) begin
            pend <= 1'b1;
            cnt  <= '0;
         end else if (tout_hit) begin
            pend <= 1'b0;
            cnt  <= '0;
         end else begin
            if (rise[5])
               pend <= 1'b0;
            if (pend && cnt != TOUT_MAX)
               cnt <= cnt + 1'b1;
         end

         // Sets are written after clears so that they win on collision
         if (rd_stat) begin
            ovr  <= 1'b0;
            tout <= 1'b0;
         end
         if (wr_cmd && pend)
            ovr <= 1'b1;
         if (tout_hit && !wr_cmd)
            tout <= 1'b1;

         if (rise[6]) reply[7:0]  <= p0o;
         if (rise[7]) reply[15:8] <= p0o;

         if (rd_data) rv <= 1'b0;
         if (rise[7]) rv <= 1'b1;

         intn      <= ~(pend & p2o[3]);
         rply_irqn <= ~rv;
      end
   end

endmodule

// File: tb/tb_jtcop_mcu_mailbox.sv
// Directed bench for jtcop_mcu_mailbox: stimulus pushes expected values into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_jtcop_mcu_mailbox;

   localparam int TOUT_W = 4;

   localparam int SEL_DOUT = 0;
   localparam int SEL_INTN = 1;
   localparam int SEL_RPLY = 2;
   localparam int SEL_P0I  = 3;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cs = 1'b0;
   logic        addr = 1'b0;
   logic        rnw = 1'b1;
   logic [1:0]  dsn = 2'b11;
   logic [15:0] cpu_dout = 16'h0000;
   logic [15:0] dout;
   logic [7:0]  p2o = 8'hFF;
   logic [7:0]  p0o = 8'h00;
   logic [7:0]  p0i;
   logic        intn;
   logic        rply_irqn;

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] exp;
   } exp_t;

   exp_t        sb[$];
   logic        chk_req = 1'b0;
   int          checks = 0;
   int          errors = 0;
   exp_t        cur;
   logic [15:0] obs;

   jtcop_mcu_mailbox #(.TOUT_W(TOUT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cs        (cs),
      .addr      (addr),
      .rnw       (rnw),
      .dsn       (dsn),
      .cpu_dout  (cpu_dout),
      .dout      (dout),
      .p2o       (p2o),
      .p0o       (p0o),
      .p0i       (p0i),
      .intn      (intn),
      .rply_irqn (rply_irqn)
   );

   always #5 clk = ~clk;

   // Monitor: one comparison per requested observation
   always @(negedge clk) begin
      if (chk_req) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: observation requested with no expected value queued");
         end else begin
            cur = sb.pop_front();
            case (cur.sel)
               SEL_DOUT: obs = dout;
               SEL_INTN: obs = {15'd0, intn};
               SEL_RPLY: obs = {15'd0, rply_irqn};
               default:  obs = {8'd0, p0i};
            endcase
            checks++;
            if (obs !== cur.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
            end else begin
               $display("check %s: got %h ok", cur.name, obs);
            end
         end
      end
   end

   task automatic chk(input string name, input int sel, input logic [15:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = val;
      sb.push_back(e);
      chk_req = 1'b1;
      @(posedge clk); #1;
      chk_req = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // One CPU bus access followed by an idle cycle so the next one starts fresh
   task automatic cpu_acc(input logic a, input logic r, input logic [1:0] d, input logic [15:0] data);
      cs = 1'b1; addr = a; rnw = r; dsn = d; cpu_dout = data;
      @(posedge clk); #1;
      cs = 1'b0; rnw = 1'b1; dsn = 2'b11;
      @(posedge clk); #1;
   endtask

   task automatic cpu_wr(input logic [1:0] d, input logic [15:0] data);
      cpu_acc(1'b0, 1'b0, d, data);
   endtask

   task automatic rd_status(input string name, input logic [15:0] val);
      cpu_acc(1'b1, 1'b1, 2'b00, 16'h0000);
      chk(name, SEL_DOUT, val);
   endtask

   task automatic rd_data(input string name, input logic [15:0] val);
      cpu_acc(1'b0, 1'b1, 2'b00, 16'h0000);
      chk(name, SEL_DOUT, val);
   endtask

   // Low for one cycle, high on the next: the rising edge is seen by the edge on return
   task automatic mcu_pulse(input int b);
      p2o[b] = 1'b0;
      @(posedge clk); #1;
      p2o[b] = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(4);
      rstn = 1'b1;
      tick(10);

      // Reset / idle state
      chk("reset_intn", SEL_INTN, 16'h0001);
      chk("reset_rply_irqn", SEL_RPLY, 16'h0001);
      chk("reset_p0i", SEL_P0I, 16'h0000);
      chk("reset_dout", SEL_DOUT, 16'h0000);
      rd_status("reset_status", 16'h0000);

      // Command handshake
      cpu_wr(2'b00, 16'hA55A);
      chk("cmd_intn_low", SEL_INTN, 16'h0000);
      rd_status("cmd_status_pend", 16'h0001);
      mcu_pulse(4);
      chk("cmd_p0i_hi", SEL_P0I, 16'h00A5);
      mcu_pulse(5);
      chk("cmd_p0i_lo", SEL_P0I, 16'h005A);
      chk("cmd_intn_release", SEL_INTN, 16'h0001);
      rd_status("cmd_status_done", 16'h0000);

      // Interrupt acknowledge masking via P2.3
      cpu_wr(2'b00, 16'h2211);
      p2o[3] = 1'b0;
      tick(1);
      chk("ack_intn_masked", SEL_INTN, 16'h0001);
      p2o[3] = 1'b1;
      tick(1);
      chk("ack_intn_reassert", SEL_INTN, 16'h0000);
      mcu_pulse(5);
      chk("ack_p0i_lo", SEL_P0I, 16'h0011);

      // Reply path
      p0o = 8'h34;
      mcu_pulse(6);
      p0o = 8'h12;
      mcu_pulse(7);
      tick(1);
      chk("rply_irq_low", SEL_RPLY, 16'h0000);
      rd_data("rply_data", 16'h1234);
      rd_status("rply_status_rv_clear", 16'h0000);
      chk("rply_irq_high", SEL_RPLY, 16'h0001);

      // Overrun
      cpu_wr(2'b00, 16'h0102);
      cpu_wr(2'b00, 16'h0304);
      rd_status("ovr_status", 16'h0005);
      rd_status("ovr_status_cleared", 16'h0001);
      mcu_pulse(4);
      chk("ovr_p0i_hi", SEL_P0I, 16'h0003);
      mcu_pulse(5);
      chk("ovr_p0i_lo", SEL_P0I, 16'h0004);

      // Timeout: no MCU strobes for well over 2^TOUT_W-1 cycles
      cpu_wr(2'b00, 16'hBEEF);
      tick(20);
      chk("tout_intn", SEL_INTN, 16'h0001);
      rd_status("tout_status", 16'h0008);
      rd_status("tout_status_cleared", 16'h0000);

      // Byte strobes: none active is ignored, lower only keeps the upper byte
      cpu_wr(2'b11, 16'h1234);
      rd_status("dsn_none_status", 16'h0000);
      cpu_wr(2'b10, 16'h77CC);
      mcu_pulse(4);
      chk("dsn_lo_p0i_hi", SEL_P0I, 16'h00BE);
      mcu_pulse(5);
      chk("dsn_lo_p0i_lo", SEL_P0I, 16'h00CC);

      // CPU write on the same edge as the low-byte strobe
      cpu_wr(2'b00, 16'hAB01);
      p2o[5] = 1'b0;
      tick(1);
      p2o[5] = 1'b1;
      cs = 1'b1; addr = 1'b0; rnw = 1'b0; dsn = 2'b00; cpu_dout = 16'hCD02;
      tick(1);
      cs = 1'b0; rnw = 1'b1; dsn = 2'b11;
      tick(1);
      chk("coll_wr_p0i_old", SEL_P0I, 16'h0001);
      rd_status("coll_wr_status", 16'h0005);
      mcu_pulse(5);
      chk("coll_wr_p0i_new", SEL_P0I, 16'h0002);
      rd_status("coll_wr_status_done", 16'h0000);

      // CPU data read on the same edge as the high reply strobe
      p0o = 8'h56;
      p2o[7] = 1'b0;
      tick(1);
      p2o[7] = 1'b1;
      cs = 1'b1; addr = 1'b0; rnw = 1'b1; dsn = 2'b00;
      tick(1);
      cs = 1'b0; dsn = 2'b11;
      tick(1);
      chk("coll_rd_dout_old", SEL_DOUT, 16'h1234);
      rd_status("coll_rd_status_rv", 16'h0002);
      rd_data("coll_rd_data_new", 16'h5634);
      rd_status("coll_rd_status_done", 16'h0000);

      tick(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
